// File: rtl/gerador_borda_pkg.sv
// Shared types and helpers for the gerador_borda edge generator.
// FSM state encoding plus the timer-width helper used to size per-channel timers.
package gerador_borda_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } estado_t;

    // Timer must hold max(HIGH_CYC, LOW_CYC)-1; one spare bit keeps it safe for powers of two.
    function automatic int unsigned timer_w(input int unsigned high_cyc,
                                            input int unsigned low_cyc);
        int unsigned m;
        m = (high_cyc > low_cyc) ? high_cyc : low_cyc;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/gerador_borda_if.sv
// Request/level bundle between a requester and gerador_borda.
// master drives pulso; slave (the generator) drives saida, ocupado and overflow.
interface gerador_borda_if #(
    parameter int unsigned WIDTH = 2
);
    logic [WIDTH-1:0] pulso;
    logic [WIDTH-1:0] saida;
    logic [WIDTH-1:0] ocupado;
    logic [WIDTH-1:0] overflow;

    modport master (output pulso, input saida, ocupado, overflow);
    modport slave  (input pulso, output saida, ocupado, overflow);
endinterface

// File: rtl/gerador_borda_canal.sv
// One edge-generator channel: IDLE/HIGH/LOW FSM, reload timer, saturating pending counter.
// GERADOR_BORDA_STICKY_OVF_EN: overflow holds until reset; otherwise one pulse per drop.
module gerador_borda_canal
    import gerador_borda_pkg::*;
#(
    parameter int unsigned HIGH_CYC = 1,
    parameter int unsigned LOW_CYC  = 1,
    parameter int unsigned CNT_W    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pulso,
    output logic saida,
    output logic ocupado,
    output logic overflow
);
    localparam int unsigned TW = timer_w(HIGH_CYC, LOW_CYC);

    estado_t          estado, estado_nx;
    logic [TW-1:0]    timer, timer_nx;
    logic [CNT_W-1:0] pend, pend_nx;
    logic             ovf, ovf_nx;

    logic pend_nz, pend_max, fim_low, start, consome, direto, descarta, aceita;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado <= ST_IDLE;
            timer  <= '0;
            pend   <= '0;
            ovf    <= 1'b0;
        end else begin
            estado <= estado_nx;
            timer  <= timer_nx;
            pend   <= pend_nx;
            ovf    <= ovf_nx;
        end
    end

    always_comb begin
        pend_nz  = (pend != '0);
        pend_max = (pend == '1);
        fim_low  = (estado == ST_LOW) && (timer == '0);
        start    = ((estado == ST_IDLE) || fim_low) && (pulso || pend_nz);
        consome  = start && pend_nz;
        // A start with nothing queued uses the live pulse, so it never enters the counter.
        direto   = start && !pend_nz;
        descarta = pulso && pend_max && !consome;
        aceita   = pulso && !direto && !descarta;

        pend_nx = pend;
        unique case ({aceita, consome})
            2'b10:   pend_nx = pend + CNT_W'(1);
            2'b01:   pend_nx = pend - CNT_W'(1);
            default: pend_nx = pend;
        endcase

        estado_nx = estado;
        timer_nx  = timer;
        case (estado)
            ST_IDLE: begin
                if (start) begin
                    estado_nx = ST_HIGH;
                    timer_nx  = TW'(HIGH_CYC - 1);
                end
            end
            ST_HIGH: begin
                if (timer == '0) begin
                    estado_nx = ST_LOW;
                    timer_nx  = TW'(LOW_CYC - 1);
                end else begin
                    timer_nx = timer - TW'(1);
                end
            end
            ST_LOW: begin
                if (timer != '0) begin
                    timer_nx = timer - TW'(1);
                end else if (start) begin
                    estado_nx = ST_HIGH;
                    timer_nx  = TW'(HIGH_CYC - 1);
                end else begin
                    estado_nx = ST_IDLE;
                    timer_nx  = '0;
                end
            end
            default: begin
                estado_nx = ST_IDLE;
                timer_nx  = '0;
            end
        endcase

`ifdef GERADOR_BORDA_STICKY_OVF_EN
        ovf_nx = ovf | descarta;
`else
        ovf_nx = descarta;
`endif
    end

    always_comb begin
        saida    = (estado == ST_HIGH);
        ocupado  = (estado != ST_IDLE) || (pend != '0);
        overflow = ovf;
    end

endmodule

// File: rtl/gerador_borda.sv
// Edge generator top: WIDTH independent gerador_borda_canal channels behind gerador_borda_if.
// GERADOR_BORDA_STICKY_OVF_EN selects sticky overflow flags (see gerador_borda_canal).
module gerador_borda
    import gerador_borda_pkg::*;
#(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned HIGH_CYC = 1,
    parameter int unsigned LOW_CYC  = 1,
    parameter int unsigned CNT_W    = 2
) (
    input logic             clk,
    input logic             rst,
    gerador_borda_if.slave  bus
);
    logic [WIDTH-1:0] saida_v, ocupado_v, overflow_v;

    for (genvar i = 0; i < WIDTH; i++) begin : g_canal
        gerador_borda_canal #(
            .HIGH_CYC (HIGH_CYC),
            .LOW_CYC  (LOW_CYC),
            .CNT_W    (CNT_W)
        ) u_canal (
            .clk      (clk),
            .rst      (rst),
            .pulso    (bus.pulso[i]),
            .saida    (saida_v[i]),
            .ocupado  (ocupado_v[i]),
            .overflow (overflow_v[i])
        );
    end

    assign bus.saida    = saida_v;
    assign bus.ocupado  = ocupado_v;
    assign bus.overflow = overflow_v;

endmodule

// File: tb/tb_gerador_borda.sv
// Directed table-driven bench for gerador_borda (default params) plus a HIGH_CYC=3/LOW_CYC=2 copy.
// Overflow expectations follow GERADOR_BORDA_STICKY_OVF_EN when it is defined.
module tb_gerador_borda;

`ifdef GERADOR_BORDA_STICKY_OVF_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk;
    logic rst;

    gerador_borda_if #(.WIDTH(2)) bus ();
    gerador_borda_if #(.WIDTH(1)) bus5 ();

    gerador_borda #(.WIDTH(2), .HIGH_CYC(1), .LOW_CYC(1), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    gerador_borda #(.WIDTH(1), .HIGH_CYC(3), .LOW_CYC(2), .CNT_W(2)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit         rst_before;
        logic [1:0] pulso;
        logic [1:0] saida;
        logic [1:0] ocup;
        logic [1:0] ovf;
    } vec_t;

    vec_t tab[$];

    // Rising-edge detector on saida: recovered pulses must equal accepted requests.
    logic [1:0] prev;
    int         edges0, edges1;
    bit         lb_en;

    always @(negedge clk) begin
        if (lb_en) begin
            if (bus.saida[0] && !prev[0]) edges0 <= edges0 + 1;
            if (bus.saida[1] && !prev[1]) edges1 <= edges1 + 1;
        end
        prev <= bus.saida;
    end

    task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Async reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input string nm);
        #2;
        rst = 1'b0;
        #1;
        chk({nm, ".saida"},    bus.saida,    2'b00);
        chk({nm, ".ocupado"},  bus.ocupado,  2'b00);
        chk({nm, ".overflow"}, bus.overflow, 2'b00);
        tick();
        rst = 1'b1;
    endtask

    task automatic push(input bit r, input logic [1:0] p, input logic [1:0] s,
                        input logic [1:0] o, input logic [1:0] v);
        vec_t e;
        e.rst_before = r;
        e.pulso      = p;
        e.saida      = s;
        e.ocup       = o;
        e.ovf        = v;
        tab.push_back(e);
    endtask

    logic p5  [10];
    logic e5  [10];
    int   req0, req1;

    initial begin
        rst       = 1'b1;
        bus.pulso  = '0;
        bus5.pulso = '0;
        lb_en  = 1'b0;
        edges0 = 0;
        edges1 = 0;
        req0   = 0;
        req1   = 0;

        // Single pulse on channel 0.
        push(1, 2'b01, 2'b01, 2'b01, 2'b00);
        push(0, 2'b00, 2'b00, 2'b01, 2'b00);
        push(0, 2'b00, 2'b00, 2'b00, 2'b00);
        // Four-cycle burst: highs every other cycle, no drops.
        for (int k = 0; k < 9; k++)
            push(k == 0, (k < 4) ? 2'b01 : 2'b00,
                 (k < 7 && k % 2 == 0) ? 2'b01 : 2'b00,
                 (k < 8) ? 2'b01 : 2'b00, 2'b00);
        // Ten-cycle burst: 8 highs, drops at cycles t+7 and t+9.
        for (int k = 0; k < 17; k++)
            push(k == 0, (k < 10) ? 2'b01 : 2'b00,
                 (k <= 14 && k % 2 == 0) ? 2'b01 : 2'b00,
                 (k < 16) ? 2'b01 : 2'b00,
                 (STICKY ? (k >= 7) : (k == 7 || k == 9)) ? 2'b01 : 2'b00);

        #3;
        do_reset("rst0");

        for (int i = 0; i < tab.size(); i++) begin
            if (tab[i].rst_before) do_reset($sformatf("rst_vec%0d", i));
            bus.pulso = tab[i].pulso;
            tick();
            chk($sformatf("vec%0d.saida", i),    bus.saida,    tab[i].saida);
            chk($sformatf("vec%0d.ocupado", i),  bus.ocupado,  tab[i].ocup);
            chk($sformatf("vec%0d.overflow", i), bus.overflow, tab[i].ovf);
        end
        bus.pulso = '0;

        // HIGH_CYC=3, LOW_CYC=2: back-to-back pulses give 1,1,1,0,0,1,1,1,0,0.
        do_reset("rst_p5");
        p5 = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        e5 = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
        for (int i = 0; i < 10; i++) begin
            bus5.pulso[0] = p5[i];
            tick();
            chk($sformatf("p5_%0d.saida", i), {1'b0, bus5.saida[0]}, {1'b0, e5[i]});
        end
        tick();
        chk("p5.ocupado_end", {1'b0, bus5.ocupado[0]}, 2'b00);

        // Mid-operation reset discards queued requests; then channel 1 alone.
        do_reset("rst_m6");
        bus.pulso = 2'b11;
        tick();
        tick();
        tick();
        chk("m6.saida_high", bus.saida,   2'b11);
        chk("m6.ocup_pre",   bus.ocupado, 2'b11);
        bus.pulso = 2'b00;
        #2;
        rst = 1'b0;
        #1;
        chk("m6.saida_rst", bus.saida,   2'b00);
        chk("m6.ocup_rst",  bus.ocupado, 2'b00);
        tick();
        rst = 1'b1;
        tick();
        chk("m6.saida_after", bus.saida,   2'b00);
        chk("m6.ocup_after",  bus.ocupado, 2'b00);
        bus.pulso = 2'b10;
        tick();
        chk("m6.ch1_high", bus.saida, 2'b10);
        bus.pulso = 2'b00;
        tick();
        chk("m6.ch1_low", bus.saida, 2'b00);
        tick();
        chk("m6.ch1_idle", bus.ocupado, 2'b00);

        // Loopback: sparse requests never saturate, so every request yields one edge.
        do_reset("rst_lb");
        lb_en = 1'b1;
        for (int c = 0; c < 60; c++) begin
            bus.pulso[0] = (c % 3 == 0);
            bus.pulso[1] = (c % 5 == 0) || (c == 31);
            if (bus.pulso[0]) req0++;
            if (bus.pulso[1]) req1++;
            tick();
        end
        bus.pulso = '0;
        for (int c = 0; c < 20; c++) tick();
        lb_en = 1'b0;
        chk_int("lb.edges0", edges0, req0);
        chk_int("lb.edges1", edges1, req1);
        chk("lb.overflow", bus.overflow, 2'b00);
        chk("lb.ocupado",  bus.ocupado,  2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
